gate_route_ctrl: RTL and testbench

//  Owns the receive-gate route-capability table and shares it between N_REQ lookup requesters.

---
 rtl/gate_route_ctrl_pkg.sv | 33 +++
 rtl/gate_rr_arb.sv | 31 +++
 rtl/gate_route_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gate_route_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_route_ctrl_pkg.sv
// Shared types for the receive-gate route-capability controller: table entry,
// route word field layout and controller FSM states.
package gate_route_ctrl_pkg;

  localparam int MAX_PORTS = 4;

  typedef struct packed {
    logic       valid;
    logic [2:0] ul_id;
  } route_cap_t;

  typedef struct packed {
    logic       inv;
    logic [1:0] rsvd;
    logic [2:0] ul_id;
    logic [1:0] port;
  } route_word_t;

  typedef enum logic [1:0] {
    GC_IDLE,
    GC_LOOKUP,
    GC_RESP
  } gate_ctrl_state_t;

  function automatic int req_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic port_in_range(input logic [1:0] p, input int n_ports);
    return int'(p) < n_ports;
  endfunction

endpackage

// File: rtl/gate_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after the pointer. The pointer register lives in the caller.
module gate_rr_arb #(
  parameter int N_REQ    = 2,
  parameter int REQ_BITS = 1
) (
  input  logic [N_REQ-1:0]    req_i,
  input  logic [REQ_BITS-1:0] ptr_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [REQ_BITS-1:0] gnt_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = REQ_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/gate_route_ctrl.sv
// Route-capability table shared between host config writes and round-robin lookups.
// Optional hit/miss statistics counters are built when GATE_ROUTE_STATS_EN is defined.
module gate_route_ctrl
  import gate_route_ctrl_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int N_REQ         = 2,
  parameter int CFG_BURST_MAX = 4,
  localparam int REQ_BITS     = req_bits(N_REQ)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_data,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*8-1:0]  req_route,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [REQ_BITS-1:0] rsp_req_id,
  output logic                rsp_hit,
  output logic [1:0]          rsp_port
`ifdef GATE_ROUTE_STATS_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  input  logic                stats_clr
`endif
);

  gate_ctrl_state_t    state_q, state_d;
  route_cap_t          table_q [MAX_PORTS];
  logic [REQ_BITS-1:0] ptr_q, ptr_d;
  logic [3:0]          burst_q, burst_d;
  logic [REQ_BITS-1:0] lkp_id_q, lkp_id_d;
  logic [1:0]          lkp_port_q, lkp_port_d;
  logic [2:0]          lkp_ul_q, lkp_ul_d;
  logic [REQ_BITS-1:0] rsp_id_q, rsp_id_d;
  logic                hit_q, hit_d;
  logic [1:0]          port_q, port_d;

  route_word_t         cfg_word, sel_word;
  route_cap_t          lkp_cap;
  logic [N_REQ-1:0]    gnt;
  logic [REQ_BITS-1:0] gnt_idx;
  logic                any_req, burst_ok, cfg_fire;
  logic                unused_bits;

  assign cfg_word    = route_word_t'(cfg_data);
  assign any_req     = |req_valid;
  assign burst_ok    = burst_q < 4'(CFG_BURST_MAX);
  assign lkp_cap     = table_q[lkp_port_q];
  assign unused_bits = ^{cfg_word.inv & 1'b0, cfg_word.rsvd, req_route};

  gate_rr_arb #(
    .N_REQ    (N_REQ),
    .REQ_BITS (REQ_BITS)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_word = route_word_t'(req_route[i*8 +: 8]);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    lkp_id_d   = lkp_id_q;
    lkp_port_d = lkp_port_q;
    lkp_ul_d   = lkp_ul_q;
    rsp_id_d   = rsp_id_q;
    hit_d      = hit_q;
    port_d     = port_q;
    cfg_ready  = 1'b0;
    cfg_fire   = 1'b0;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state_q)
      GC_IDLE: begin
        // Pending lookups cap how many config writes may starve them.
        cfg_ready = cfg_valid && (!any_req || burst_ok);
        cfg_fire  = cfg_ready;
        if (cfg_fire) begin
          if (any_req) burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
          else         burst_d = '0;
        end else if (any_req) begin
          req_ready  = gnt;
          lkp_id_d   = gnt_idx;
          lkp_port_d = sel_word.port;
          lkp_ul_d   = sel_word.ul_id;
          ptr_d      = (gnt_idx == REQ_BITS'(N_REQ - 1)) ? '0 : gnt_idx + REQ_BITS'(1);
          burst_d    = '0;
          state_d    = GC_LOOKUP;
        end
      end
      GC_LOOKUP: begin
        hit_d    = port_in_range(lkp_port_q, N_PORTS) && lkp_cap.valid &&
                   (lkp_cap.ul_id == lkp_ul_q);
        port_d   = hit_d ? lkp_port_q : 2'b00;
        rsp_id_d = lkp_id_q;
        state_d  = GC_RESP;
      end
      GC_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = GC_IDLE;
      end
      default: state_d = GC_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= GC_IDLE;
      ptr_q      <= '0;
      burst_q    <= '0;
      lkp_id_q   <= '0;
      lkp_port_q <= '0;
      lkp_ul_q   <= '0;
      rsp_id_q   <= '0;
      hit_q      <= 1'b0;
      port_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      lkp_id_q   <= lkp_id_d;
      lkp_port_q <= lkp_port_d;
      lkp_ul_q   <= lkp_ul_d;
      rsp_id_q   <= rsp_id_d;
      hit_q      <= hit_d;
      port_q     <= port_d;
    end
  end

  // Out-of-range ports are still handshaken but never land in the table.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < MAX_PORTS; i++) table_q[i] <= '0;
    end else if (cfg_fire && port_in_range(cfg_word.port, N_PORTS)) begin
      table_q[cfg_word.port] <= '{valid: ~cfg_word.inv, ul_id: cfg_word.ul_id};
    end
  end

  assign rsp_req_id = rsp_id_q;
  assign rsp_hit    = hit_q;
  assign rsp_port   = port_q;

`ifdef GATE_ROUTE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stats_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (hit_q && hit_cnt_q != 32'hFFFF_FFFF)        hit_cnt_q  <= hit_cnt_q + 32'd1;
      else if (!hit_q && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_gate_route_ctrl.sv
// Directed self-checking bench for gate_route_ctrl: lookups, config writes,
// round-robin order, config burst limit, response stall and reset mid-lookup.
module tb_gate_route_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_route;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_req_id;
  logic        rsp_hit;
  logic [1:0]  rsp_port;
`ifdef GATE_ROUTE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  logic        stats_clr = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;

  gate_route_ctrl #(
    .N_PORTS       (4),
    .N_REQ         (2),
    .CFG_BURST_MAX (4)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_route  (req_route),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_req_id (rsp_req_id),
    .rsp_hit    (rsp_hit),
    .rsp_port   (rsp_port)
`ifdef GATE_ROUTE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .stats_clr  (stats_clr)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    areset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    req_valid = 2'b00;
    req_route = 16'h0000;
    rsp_ready = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic do_cfg(input logic [7:0] data);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_data  = data;
    #1;
    while (cfg_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL cfg_accept data=%h: cfg_ready never rose within 20 cycles", data);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [1:0] mask, input logic [15:0] routes,
                           input logic [1:0] exp_gnt, input logic exp_hit,
                           input logic [1:0] exp_port, input logic exp_id);
    int n = 0;
    req_route = routes;
    req_valid = mask;
    #1;
    while (req_ready === 2'b00 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (req_ready !== exp_gnt) begin
      miscompares++;
      $display("FAIL lkp_grant: req_ready=%b expected %b", req_ready, exp_gnt);
    end
    tick();
    req_valid = 2'b00;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lkp_early_rsp: rsp_valid=%b expected 0 in lookup cycle", rsp_valid);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_hit !== exp_hit || rsp_port !== exp_port ||
        rsp_req_id !== exp_id) begin
      miscompares++;
      $display("FAIL lkp_rsp route=%h: valid=%b hit=%b port=%0d id=%0d expected 1 %b %0d %0d",
               routes, rsp_valid, rsp_hit, rsp_port, rsp_req_id, exp_hit, exp_port, exp_id);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lkp_rsp_drop: rsp_valid=%b expected 0 after handshake", rsp_valid);
    end
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    req_valid = 2'b00;
    req_route = 16'h0000;
    rsp_ready = 1'b1;
    #3;
    vectors++;
    if (cfg_ready !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 1'b0 ||
        rsp_req_id !== 1'b0 || rsp_hit !== 1'b0 || rsp_port !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: cfg_rdy=%b req_rdy=%b rsp_v=%b id=%b hit=%b port=%0d expected all 0",
               cfg_ready, req_ready, rsp_valid, rsp_req_id, rsp_hit, rsp_port);
    end
    tick();
    areset = 1'b0;
    tick();
    vectors++;
    if (cfg_ready !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: cfg_rdy=%b req_rdy=%b rsp_v=%b expected 0 0 0",
               cfg_ready, req_ready, rsp_valid);
    end
  endtask

  task automatic test_miss_after_reset();
    do_lookup(2'b01, 16'h000D, 2'b01, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_cfg_hit();
    do_cfg(8'h0D);
    do_lookup(2'b01, 16'h000D, 2'b01, 1'b1, 2'd1, 1'b0);
    do_lookup(2'b10, 16'h1100, 2'b10, 1'b0, 2'd0, 1'b1);
    do_cfg(8'h8D);
    do_lookup(2'b01, 16'h000D, 2'b01, 1'b0, 2'd0, 1'b0);
    do_cfg(8'h83);
    do_lookup(2'b10, 16'h0300, 2'b10, 1'b0, 2'd0, 1'b1);
    do_cfg(8'h6E);
    do_lookup(2'b01, 16'h000E, 2'b01, 1'b1, 2'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] gnt_seen [4];
    logic       id_seen  [4];
    logic       hit_seen [4];
    int         cyc_seen [4];
    logic [1:0] exp_gnt  [4];
    logic       exp_hit  [4];
    int         ng = 0;
    int         nr = 0;
    int         cyc = 0;
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_hit = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    do_cfg(8'h0D);
    req_route = 16'h120D;
    req_valid = 2'b11;
    while (nr < 4 && cyc < 60) begin
      #1;
      if (req_ready !== 2'b00 && ng < 4) begin
        gnt_seen[ng] = req_ready;
        ng++;
      end
      if (rsp_valid === 1'b1 && nr < 4) begin
        id_seen[nr]  = rsp_req_id;
        hit_seen[nr] = rsp_hit;
        cyc_seen[nr] = cyc;
        nr++;
      end
      tick();
      if (ng == 4) req_valid = 2'b00;
      cyc++;
    end
    vectors++;
    if (nr != 4) begin
      miscompares++;
      $display("FAIL rr_timeout: %0d responses seen, expected 4", nr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (gnt_seen[i] !== exp_gnt[i] || id_seen[i] !== exp_gnt[i][1] ||
            hit_seen[i] !== exp_hit[i]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: gnt=%b id=%b hit=%b expected %b %b %b",
                   i, gnt_seen[i], id_seen[i], hit_seen[i], exp_gnt[i], exp_gnt[i][1], exp_hit[i]);
        end
        if (i > 0) begin
          vectors++;
          if (cyc_seen[i] - cyc_seen[i-1] != 3) begin
            miscompares++;
            $display("FAIL rr_spacing[%0d]: %0d cycles expected 3", i, cyc_seen[i] - cyc_seen[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [9:0] exp_cfg = 10'b11_1000_1111;
    logic [9:0] exp_gnt = 10'b00_0001_0000;
    logic       granted;
    apply_reset();
    req_route = 16'h000D;
    req_valid = 2'b01;
    cfg_data  = 8'h0D;
    cfg_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++;
      if (cfg_ready !== exp_cfg[c] || req_ready[0] !== exp_gnt[c]) begin
        miscompares++;
        $display("FAIL burst_cyc%0d: cfg_ready=%b req_ready0=%b expected %b %b",
                 c, cfg_ready, req_ready[0], exp_cfg[c], exp_gnt[c]);
      end
      if (c == 6) begin
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_port !== 2'd1) begin
          miscompares++;
          $display("FAIL burst_rsp: valid=%b hit=%b port=%0d expected 1 1 1",
                   rsp_valid, rsp_hit, rsp_port);
        end
      end
      granted = req_ready[0];
      tick();
      if (granted) req_valid = 2'b00;
    end
    cfg_valid = 1'b0;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_stall();
    int n = 0;
    rsp_ready = 1'b0;
    req_route = 16'h0D00;
    req_valid = 2'b10;
    #1;
    while (req_ready === 2'b00 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_grant: req_ready=%b expected 10", req_ready);
    end
    tick();
    cfg_data  = 8'h80;
    cfg_valid = 1'b1;
    req_valid = 2'b11;
    #1;
    vectors++;
    if (cfg_ready !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_lookup_blocked: cfg_ready=%b req_ready=%b expected 0 00", cfg_ready, req_ready);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_req_id !== 1'b1 || rsp_hit !== 1'b1 || rsp_port !== 2'd1 ||
          cfg_ready !== 1'b0 || req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL stall_cyc%0d: v=%b id=%b hit=%b port=%0d cfg_rdy=%b req_rdy=%b expected 1 1 1 1 0 00",
                 c, rsp_valid, rsp_req_id, rsp_hit, rsp_port, cfg_ready, req_ready);
      end
      tick();
    end
    cfg_valid = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset_in_lookup();
    int n = 0;
    int seen = 0;
    do_cfg(8'h1A);
    req_route = 16'h1A00;
    req_valid = 2'b10;
    #1;
    while (req_ready === 2'b00 && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid = 2'b00;
    areset    = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_lookup_rsp: rsp_valid=%b expected 0 under reset", rsp_valid);
    end
    tick();
    tick();
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_lookup_dropped: rsp_valid high %0d cycles expected 0", seen);
    end
    do_lookup(2'b11, 16'h1A0D, 2'b01, 1'b0, 2'd0, 1'b0);
    do_lookup(2'b10, 16'h1A00, 2'b10, 1'b0, 2'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_miss_after_reset();
    test_cfg_hit();
    test_back_to_back();
    test_burst();
    test_stall();
    test_reset_in_lookup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
